// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_ctrl
//  Description : Bit-serial add/subtract sequencer driving one external fas
//                cell LSB-first, holding each bit SETTLE clocks and
//                registering the carry/borrow between bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl #(
    parameter int N      = 8,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_a_ns,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    output logic         fa_a_ns,
    input  logic         fa_s,
    input  logic         fa_cout
);

    localparam int c_CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_IDX_W = $clog2(N);

    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT    = c_IDX_W'(N - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SETTLE = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [N-1:0]       r_a_sr;
    logic [N-1:0]       r_b_sr;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_op;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic [c_CNT_W-1:0] r_settle_cnt;
    logic               r_busy;
    logic               r_done;
    logic [N-1:0]       r_result;
    logic               r_cout;
    logic               r_ovf;

    logic               w_in_settle;
    logic               w_ovf;

    // Cell inputs are only live while a bit is being settled.
    always_comb begin
        w_in_settle = (r_state == c_S_SETTLE);
        // fa_s at the last capture is the result MSB.
        if (r_op) begin
            w_ovf = (r_a_msb == r_b_msb) && (fa_s != r_a_msb);
        end else begin
            w_ovf = (r_a_msb != r_b_msb) && (fa_s != r_a_msb);
        end
    end

    assign fa_a    = w_in_settle & r_a_sr[0];
    assign fa_b    = w_in_settle & r_b_sr[0];
    assign fa_cin  = w_in_settle & r_carry;
    assign fa_a_ns = r_op;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign cout    = r_cout;
    assign ovf     = r_ovf;

    // Sequencer: accept, step bits through the cell, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_op         <= 1'b1;
            r_carry      <= 1'b0;
            r_bit_idx    <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= '0;
            r_cout       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr       <= op_a;
                        r_b_sr       <= op_b;
                        r_a_msb      <= op_a[N-1];
                        r_b_msb      <= op_b[N-1];
                        r_op         <= op_a_ns;
                        r_carry      <= 1'b0;
                        r_bit_idx    <= '0;
                        r_settle_cnt <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= c_S_SETTLE;
                    end
                end
                c_S_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        // Bit settled: capture sum, carry, advance operands.
                        r_result     <= {fa_s, r_result[N-1:1]};
                        r_carry      <= fa_cout;
                        r_a_sr       <= {1'b0, r_a_sr[N-1:1]};
                        r_b_sr       <= {1'b0, r_b_sr[N-1:1]};
                        r_settle_cnt <= '0;
                        r_bit_idx    <= r_bit_idx + 1'b1;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_cout  <= fa_cout;
                            r_ovf   <= w_ovf;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_S_DONE;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                c_S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
